// File: rtl/vx_commit_pkg.sv
// Shared types and constants for the commit stage: the commit payload layout,
// arbiter selector encodings and the thread-count helper.
package vx_commit_pkg;

   localparam int VX_NUM_THREADS = 4;
   localparam int VX_NUM_WARPS   = 8;
   localparam int NW_WIDTH       = (VX_NUM_WARPS > 1) ? $clog2(VX_NUM_WARPS) : 1;
   localparam int UUID_W         = 16;
   localparam int PC_W           = 32;
   localparam int NR_BITS        = 5;
   localparam int XLEN           = 32;
   localparam int COMMIT_SIZEW   = $clog2(VX_NUM_THREADS + 1);

   localparam logic [7:0] ARB_PRIORITY    = "P";
   localparam logic [7:0] ARB_ROUND_ROBIN = "R";

   typedef struct packed {
      logic [UUID_W-1:0]                    uuid;
      logic [NW_WIDTH-1:0]                  wid;
      logic [VX_NUM_THREADS-1:0]            tmask;
      logic [PC_W-1:0]                      PC;
      logic                                 wb;
      logic [NR_BITS-1:0]                   rd;
      logic [VX_NUM_THREADS-1:0][XLEN-1:0]  data;
      logic                                 sop;
      logic                                 eop;
   } commit_data_t;

   localparam int COMMIT_DATAW = $bits(commit_data_t);

   function automatic logic [COMMIT_SIZEW-1:0] count_ones(input logic [VX_NUM_THREADS-1:0] m);
      logic [COMMIT_SIZEW-1:0] n;
      n = '0;
      for (int t = 0; t < VX_NUM_THREADS; t++) n = n + COMMIT_SIZEW'(m[t]);
      return n;
   endfunction

endpackage

// File: rtl/vx_commit_slot.sv
// One issue slot: unit arbitration with packet lock, 2-entry elastic output
// buffer and the saturating writeback stall counter.
module vx_commit_slot
   import vx_commit_pkg::*;
#(
   parameter int         NUM_EX_UNITS = 4,
   parameter logic [7:0] ARBITER      = ARB_PRIORITY,
   parameter int         CTR_BITS     = 44
) (
   input  logic                                       clk,
   input  logic                                       reset_n,
   input  logic [NUM_EX_UNITS-1:0]                    in_valid,
   input  logic [NUM_EX_UNITS-1:0][COMMIT_DATAW-1:0]  in_data,
   output logic [NUM_EX_UNITS-1:0]                    in_ready,
   output logic                                       out_valid,
   output commit_data_t                               out_data,
   input  logic                                       out_ready,
   output logic [CTR_BITS-1:0]                        stall_cycles
);

   localparam int UW = (NUM_EX_UNITS > 1) ? $clog2(NUM_EX_UNITS) : 1;

   logic          locked;
   logic [UW-1:0] lock_idx;
   logic [UW-1:0] rr_ptr;
   logic          grant_vld;
   logic [UW-1:0] grant_idx;
   logic [UW-1:0] scan_idx;
   logic          head;
   logic [1:0]    count;
   logic          push;
   logic          pop;
   commit_data_t  push_data;
   commit_data_t  mem [2];

   // Scan from the highest offset down so the nearest eligible unit is written last.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      scan_idx  = '0;
      if (locked) begin
         grant_vld = in_valid[lock_idx];
         grant_idx = lock_idx;
      end else if (ARBITER == ARB_ROUND_ROBIN) begin
         for (int n = NUM_EX_UNITS - 1; n >= 0; n--) begin
            scan_idx = UW'((int'(rr_ptr) + n) % NUM_EX_UNITS);
            if (in_valid[scan_idx]) begin
               grant_vld = 1'b1;
               grant_idx = scan_idx;
            end
         end
      end else begin
         for (int n = NUM_EX_UNITS - 1; n >= 0; n--) begin
            scan_idx = UW'(n);
            if (in_valid[scan_idx]) begin
               grant_vld = 1'b1;
               grant_idx = scan_idx;
            end
         end
      end
   end

   // Readiness comes from the registered count, so a full buffer refuses even when popping.
   assign push      = reset_n & grant_vld & (count != 2'd2);
   assign pop       = out_valid & out_ready;
   assign push_data = commit_data_t'(in_data[grant_idx]);
   assign out_valid = (count != 2'd0);
   assign out_data  = mem[head];

   for (genvar j = 0; j < NUM_EX_UNITS; j++) begin : g_ready
      assign in_ready[j] = push & (grant_idx == UW'(j));
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count        <= 2'd0;
         head         <= 1'b0;
         locked       <= 1'b0;
         lock_idx     <= '0;
         rr_ptr       <= '0;
         stall_cycles <= '0;
      end else begin
         count <= count + {1'b0, push} - {1'b0, pop};
         if (pop) head <= ~head;
         if (push) begin
            locked   <= ~push_data.eop;
            lock_idx <= grant_idx;
            if (push_data.eop && (ARBITER == ARB_ROUND_ROBIN))
               rr_ptr <= (grant_idx == UW'(NUM_EX_UNITS - 1)) ? '0 : grant_idx + 1'b1;
         end
         if (out_valid && !out_ready && !(&stall_cycles))
            stall_cycles <= stall_cycles + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[head ^ count[0]] <= push_data;
   end

endmodule

// File: rtl/vx_commit_unit.sv
// Commit stage top: per-slot arbitration/buffering plus the retired-thread
// counter pipeline and the per-warp committed pulse.
module vx_commit_unit
   import vx_commit_pkg::*;
#(
   parameter int         NUM_EX_UNITS = 4,
   parameter int         ISSUE_WIDTH  = 2,
   parameter int         NUM_THREADS  = VX_NUM_THREADS,
   parameter int         NUM_WARPS    = VX_NUM_WARPS,
   parameter int         DATAW        = COMMIT_DATAW,
   parameter logic [7:0] ARBITER      = ARB_PRIORITY,
   parameter int         CTR_BITS     = 44
) (
   input  logic                                               clk,
   input  logic                                               reset_n,
   input  logic [NUM_EX_UNITS*ISSUE_WIDTH-1:0]                in_valid,
   input  logic [NUM_EX_UNITS*ISSUE_WIDTH-1:0][DATAW-1:0]     in_data,
   output logic [NUM_EX_UNITS*ISSUE_WIDTH-1:0]                in_ready,
   output logic [ISSUE_WIDTH-1:0]                             out_valid,
   output logic [ISSUE_WIDTH-1:0][DATAW-1:0]                  out_data,
   input  logic [ISSUE_WIDTH-1:0]                             out_ready,
   output logic [CTR_BITS-1:0]                                instret,
   output logic [ISSUE_WIDTH-1:0][CTR_BITS-1:0]               stall_cycles,
   output logic [NUM_WARPS-1:0]                               committed_warps
);

   localparam int SUM_W = $clog2(NUM_THREADS * ISSUE_WIDTH + 1);

   commit_data_t                            slot_data [ISSUE_WIDTH];
   logic [ISSUE_WIDTH-1:0]                  fire;
   logic [ISSUE_WIDTH-1:0][COMMIT_SIZEW-1:0] pop_cnt_p0;
   logic [SUM_W-1:0]                        pop_sum;
   logic [SUM_W-1:0]                        sum_p1;
   logic [NUM_WARPS-1:0]                    warp_eop;

   for (genvar i = 0; i < ISSUE_WIDTH; i++) begin : g_slot
      logic [NUM_EX_UNITS-1:0]            slot_in_valid;
      logic [NUM_EX_UNITS-1:0]            slot_in_ready;
      logic [NUM_EX_UNITS-1:0][DATAW-1:0] slot_in_data;

      for (genvar j = 0; j < NUM_EX_UNITS; j++) begin : g_unit
         assign slot_in_valid[j]             = in_valid[j*ISSUE_WIDTH+i];
         assign slot_in_data[j]              = in_data[j*ISSUE_WIDTH+i];
         assign in_ready[j*ISSUE_WIDTH+i]    = slot_in_ready[j];
      end

      vx_commit_slot #(
         .NUM_EX_UNITS (NUM_EX_UNITS),
         .ARBITER      (ARBITER),
         .CTR_BITS     (CTR_BITS)
      ) u_slot (
         .clk          (clk),
         .reset_n      (reset_n),
         .in_valid     (slot_in_valid),
         .in_data      (slot_in_data),
         .in_ready     (slot_in_ready),
         .out_valid    (out_valid[i]),
         .out_data     (slot_data[i]),
         .out_ready    (out_ready[i]),
         .stall_cycles (stall_cycles[i])
      );

      assign out_data[i] = slot_data[i];
      assign fire[i]     = out_valid[i] & out_ready[i];

      // Stage p0: per-slot popcount of the fired beat.
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) pop_cnt_p0[i] <= '0;
         else          pop_cnt_p0[i] <= fire[i] ? count_ones(slot_data[i].tmask) : '0;
      end
   end

   always_comb begin
      pop_sum  = '0;
      warp_eop = '0;
      for (int i = 0; i < ISSUE_WIDTH; i++) begin
         pop_sum = pop_sum + SUM_W'(pop_cnt_p0[i]);
         if (fire[i] && slot_data[i].eop) warp_eop[slot_data[i].wid] = 1'b1;
      end
   end

   // Stage p1: slot sum; stage p2: accumulate into instret.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sum_p1          <= '0;
         instret         <= '0;
         committed_warps <= '0;
      end else begin
         sum_p1          <= pop_sum;
         instret         <= instret + CTR_BITS'(sum_p1);
         committed_warps <= warp_eop;
      end
   end

endmodule

// File: tb/tb_vx_commit_unit.sv
// Bench: a fixed-priority and a round-robin instance driven with random packets,
// checked cycle by cycle against a queue-based reference of the commit rules.
module tb_vx_commit_unit;
   import vx_commit_pkg::*;

   localparam int NU = 4;
   localparam int IW = 2;
   localparam int NS = NU * IW;
   localparam int DW = COMMIT_DATAW;
   localparam int CB = 44;

   logic clk = 1'b0;
   logic reset_n;
   logic [NS-1:0]          in_valid  [2];
   logic [NS-1:0][DW-1:0]  in_data   [2];
   logic [NS-1:0]          in_ready  [2];
   logic [IW-1:0]          out_valid [2];
   logic [IW-1:0][DW-1:0]  out_data  [2];
   logic [IW-1:0]          out_ready [2];
   logic [CB-1:0]          instret   [2];
   logic [IW-1:0][CB-1:0]  stall_cycles [2];
   logic [7:0]             committed_warps [2];

   always #5 clk = ~clk;

   for (genvar k = 0; k < 2; k++) begin : g_dut
      vx_commit_unit #(
         .NUM_EX_UNITS (NU),
         .ISSUE_WIDTH  (IW),
         .ARBITER      ((k == 0) ? ARB_PRIORITY : ARB_ROUND_ROBIN),
         .CTR_BITS     (CB)
      ) u_dut (
         .clk             (clk),
         .reset_n         (reset_n),
         .in_valid        (in_valid[k]),
         .in_data         (in_data[k]),
         .in_ready        (in_ready[k]),
         .out_valid       (out_valid[k]),
         .out_data        (out_data[k]),
         .out_ready       (out_ready[k]),
         .instret         (instret[k]),
         .stall_cycles    (stall_cycles[k]),
         .committed_warps (committed_warps[k])
      );
   end

   // Reference state: producer packet queues, expected buffer contents, lock/pointer.
   commit_data_t src_q [2][IW][NU][$];
   commit_data_t exp_q [2][IW][$];
   int           lock_j [2][IW];
   int           ptr    [2][IW];
   logic [CB-1:0] exp_instret [2];
   logic [CB-1:0] exp_stall   [2][IW];
   logic [7:0]    exp_cw      [2];
   int            pend        [2][$];
   int compared = 0;
   int mismatched = 0;
   int uuid_ctr = 1;
   int p_valid = 60;
   int p_ready = 70;
   bit fill_en = 1'b1;

   task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic commit_data_t mk_beat(input logic [2:0] wid, input logic [3:0] tm,
                                            input bit sop, input bit eop);
      commit_data_t b;
      b.uuid  = 16'(uuid_ctr);
      uuid_ctr++;
      b.wid   = wid;
      b.tmask = tm;
      b.PC    = $urandom;
      b.wb    = 1'($urandom);
      b.rd    = 5'($urandom);
      for (int t = 0; t < VX_NUM_THREADS; t++) b.data[t] = $urandom;
      b.sop   = sop;
      b.eop   = eop;
      return b;
   endfunction

   task automatic new_packet(input int k, input int i, input int j);
      int len = $urandom_range(1, 3);
      logic [2:0] w = 3'($urandom);
      for (int n = 0; n < len; n++)
         src_q[k][i][j].push_back(mk_beat(w, 4'($urandom), n == 0, n == len - 1));
   endtask

   task automatic model_clear();
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < IW; i++) begin
            exp_q[k][i].delete();
            lock_j[k][i]    = -1;
            ptr[k][i]       = 0;
            exp_stall[k][i] = '0;
            for (int j = 0; j < NU; j++) src_q[k][i][j].delete();
         end
         exp_instret[k] = '0;
         exp_cw[k]      = '0;
         pend[k].delete();
         in_valid[k]    = '0;
         in_data[k]     = '0;
         out_ready[k]   = '0;
      end
   endtask

   task automatic drive();
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < IW; i++) begin
            for (int j = 0; j < NU; j++) begin
               if (fill_en && src_q[k][i][j].size() == 0) new_packet(k, i, j);
               in_valid[k][j*IW+i] = (src_q[k][i][j].size() != 0) && ($urandom_range(0, 99) < p_valid);
               in_data[k][j*IW+i]  = (src_q[k][i][j].size() != 0) ? src_q[k][i][j][0] : '0;
            end
            out_ready[k][i] = ($urandom_range(0, 99) < p_ready);
         end
      end
   endtask

   task automatic check_update();
      for (int k = 0; k < 2; k++) begin
         int fsum = 0;
         logic [7:0] cw_n = '0;
         check_val($sformatf("instret[%0d]", k), instret[k], exp_instret[k]);
         check_val($sformatf("committed_warps[%0d]", k), committed_warps[k], exp_cw[k]);
         for (int i = 0; i < IW; i++) begin
            int g = -1;
            bit free = (exp_q[k][i].size() < 2);
            commit_data_t b;
            if (lock_j[k][i] >= 0) begin
               if (in_valid[k][lock_j[k][i]*IW+i]) g = lock_j[k][i];
            end else begin
               for (int n = 0; n < NU; n++) begin
                  int j = (k == 0) ? n : (ptr[k][i] + n) % NU;
                  if (g < 0 && in_valid[k][j*IW+i]) g = j;
               end
            end
            for (int j = 0; j < NU; j++)
               check_val($sformatf("in_ready[%0d][u%0d s%0d]", k, j, i), in_ready[k][j*IW+i], free && g == j);
            check_val($sformatf("out_valid[%0d][%0d]", k, i), out_valid[k][i], exp_q[k][i].size() > 0);
            if (exp_q[k][i].size() > 0)
               check_val($sformatf("out_data[%0d][%0d]", k, i), out_data[k][i], exp_q[k][i][0]);
            check_val($sformatf("stall_cycles[%0d][%0d]", k, i), stall_cycles[k][i], exp_stall[k][i]);
            if (exp_q[k][i].size() > 0) begin
               if (out_ready[k][i]) begin
                  b = exp_q[k][i].pop_front();
                  fsum += $countones(b.tmask);
                  if (b.eop) cw_n[b.wid] = 1'b1;
               end else begin
                  exp_stall[k][i] = exp_stall[k][i] + 1'b1;
               end
            end
            if (free && g >= 0) begin
               b = src_q[k][i][g].pop_front();
               exp_q[k][i].push_back(b);
               if (b.eop) begin
                  lock_j[k][i] = -1;
                  if (k == 1) ptr[k][i] = (g + 1) % NU;
               end else begin
                  lock_j[k][i] = g;
               end
            end
         end
         pend[k].push_back(fsum);
         if (pend[k].size() > 2) exp_instret[k] = exp_instret[k] + CB'(pend[k].pop_front());
         exp_cw[k] = cw_n;
      end
   endtask

   task automatic run(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         drive();
         @(negedge clk);
         check_update();
      end
   endtask

   task automatic check_reset_state(input string tag);
      for (int k = 0; k < 2; k++) begin
         check_val($sformatf("%s instret[%0d]", tag, k), instret[k], '0);
         check_val($sformatf("%s committed_warps[%0d]", tag, k), committed_warps[k], '0);
         check_val($sformatf("%s in_ready[%0d]", tag, k), in_ready[k], '0);
         check_val($sformatf("%s out_valid[%0d]", tag, k), out_valid[k], '0);
         for (int i = 0; i < IW; i++)
            check_val($sformatf("%s stall_cycles[%0d][%0d]", tag, k, i), stall_cycles[k][i], '0);
      end
   endtask

   initial begin
      reset_n = 1'b0;
      model_clear();
      // Producers stay valid during reset: in_ready must still be low.
      for (int k = 0; k < 2; k++) in_valid[k] = '1;
      repeat (2) @(posedge clk);
      #1;
      check_reset_state("reset");
      for (int k = 0; k < 2; k++) in_valid[k] = '0;
      @(negedge clk);
      reset_n = 1'b1;

      p_valid = 60; p_ready = 70; run(300);
      p_valid = 100; p_ready = 100; run(100);
      p_ready = 0; run(5);
      p_ready = 100; run(20);

      // Fill buffers mid-packet, then pulse reset asynchronously.
      p_ready = 0; run(4);
      @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      check_reset_state("midreset");
      model_clear();
      @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;

      // Both slots buffer an eop beat for warp 3, then fire together.
      fill_en = 1'b0;
      for (int k = 0; k < 2; k++) begin
         src_q[k][0][0].push_back(mk_beat(3'd3, 4'b1111, 1'b1, 1'b1));
         src_q[k][1][1].push_back(mk_beat(3'd3, 4'b0101, 1'b1, 1'b1));
      end
      p_valid = 100; p_ready = 0; run(2);
      p_ready = 100; run(6);
      for (int k = 0; k < 2; k++)
         check_val($sformatf("same-wid instret[%0d]", k), instret[k], CB'(6));

      fill_en = 1'b1;
      p_valid = 80; p_ready = 50; run(300);
      p_valid = 30; p_ready = 90; run(100);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
